// File: rtl/button_pulse_gen.sv
// Button front end for the 4x4 memory game. Each of the seven raw buttons is
// synchronized, debounced and turned into one-clock pulses. Direction buttons
// auto-repeat while held. Game pulses are one-hot by fixed priority, and
// control pulses are never arbitrated.

// One button channel: 2-flop synchronizer, debounce/hold FSM, repeat timer.
// The channel asks for a pulse. The top level decides whether the pulse is
// granted and registers the output.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// ST_IDLE      | button released and settled; cnt and rpt cleared
// ST_DEB_PRESS | counting stable high samples before accepting a press
// ST_PULSE     | single cycle in which the channel's output is high
// ST_HOLD      | press accepted; counting toward next auto-repeat (if enabled)
// ST_DEB_REL   | counting stable low samples before accepting the release
module button_pulse_chan #(
  parameter int DEB_CYCLES = 500000,
  parameter int RPT_DELAY  = 50000000,
  parameter int RPT_PERIOD = 15000000,
  parameter int CNT_W      = 26,
  parameter bit REPEAT_EN  = 1'b0
) (
  input  logic Clk,
  input  logic Reset,
  input  logic btn_raw,
  input  logic grant,
  output logic pulse_req
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_DEB_PRESS = 3'd1;
  localparam logic [2:0] ST_PULSE     = 3'd2;
  localparam logic [2:0] ST_HOLD      = 3'd3;
  localparam logic [2:0] ST_DEB_REL   = 3'd4;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(RPT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(RPT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1;
  logic             s2;
  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] rpt_last;
  logic             rpt_q;
  logic             rpt_d;
  logic             mute_q;

  // Bring the asynchronous button into the Clk domain.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // The first repeat waits the longer delay. Later repeats use the period.
  assign rpt_last = rpt_q ? PER_LAST : DLY_LAST;

  // Next-state, counter and repeat-flag logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rpt_d   = rpt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        rpt_d = 1'b0;
        if (s2) state_d = ST_DEB_PRESS;
      end
      ST_DEB_PRESS: begin
        if (!s2) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_PULSE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_PULSE: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end
      ST_HOLD: begin
        // Release wins over a repeat that would fire on the same edge.
        if (!s2) begin
          state_d = ST_DEB_REL;
          cnt_d   = '0;
        end else if (REPEAT_EN) begin
          if (cnt_q == rpt_last) begin
            state_d = ST_PULSE;
            cnt_d   = '0;
            rpt_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      ST_DEB_REL: begin
        // A bounce goes back to HOLD and restarts the repeat timer.
        // The repeat phase is kept.
        if (s2) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        rpt_d   = 1'b0;
      end
    endcase
  end

  // A muted channel still runs its FSM but never requests a pulse.
  assign pulse_req = (state_d == ST_PULSE) && !mute_q;

  // State, counter and repeat flag registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rpt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rpt_q   <= rpt_d;
    end
  end

  // A press that loses arbitration is dropped, not deferred. The channel
  // stays silent, including its repeats, until the button is released.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mute_q <= 1'b0;
    end else if (state_d == ST_IDLE) begin
      mute_q <= 1'b0;
    end else if (pulse_req && !grant) begin
      mute_q <= 1'b1;
    end
  end

endmodule

module button_pulse_gen #(
  parameter int DEB_CYCLES = 500000,
  parameter int RPT_DELAY  = 50000000,
  parameter int RPT_PERIOD = 15000000,
  parameter int CNT_W      = 26
) (
  input  logic Clk,
  input  logic Reset,
  input  logic BtnR,
  input  logic BtnL,
  input  logic BtnU,
  input  logic BtnD,
  input  logic BtnC,
  input  logic BtnStart,
  input  logic BtnAck,
  output logic Right,
  output logic Left,
  output logic Up,
  output logic Down,
  output logic Select,
  output logic Start,
  output logic Ack
);

  // Channel order: R, L, U, D, C (game, priority high to low), Start, Ack.
  localparam int NUM_CH  = 7;
  localparam int GAME_CH = 5;

  logic [NUM_CH-1:0] btn_raw;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] grant;
  logic [NUM_CH-1:0] pulse_q;
  logic              taken;

  assign btn_raw = {BtnAck, BtnStart, BtnC, BtnD, BtnU, BtnL, BtnR};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
      button_pulse_chan #(
        .DEB_CYCLES (DEB_CYCLES),
        .RPT_DELAY  (RPT_DELAY),
        .RPT_PERIOD (RPT_PERIOD),
        .CNT_W      (CNT_W),
        .REPEAT_EN  (gi < 4)
      ) u_chan (
        .Clk       (Clk),
        .Reset     (Reset),
        .btn_raw   (btn_raw[gi]),
        .grant     (grant[gi]),
        .pulse_req (req[gi])
      );
    end
  endgenerate

  // Fixed-priority grant among game channels. Control channels always win.
  always_comb begin
    grant = '1;
    taken = 1'b0;
    for (int i = 0; i < GAME_CH; i++) begin
      grant[i] = !taken;
      taken    = taken | req[i];
    end
  end

  // Register the granted pulses. Each is high for exactly the PULSE cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pulse_q <= '0;
    end else begin
      pulse_q <= req & grant;
    end
  end

  assign Right  = pulse_q[0];
  assign Left   = pulse_q[1];
  assign Up     = pulse_q[2];
  assign Down   = pulse_q[3];
  assign Select = pulse_q[4];
  assign Start  = pulse_q[5];
  assign Ack    = pulse_q[6];

endmodule

// File: tb/tb_button_pulse_gen.sv
// Bench for button_pulse_gen: directed scenarios followed by random button
// activity. Every output is checked every cycle against a run-length model
// of press/hold/release behaviour.
module tb_button_pulse_gen;

  localparam int DEB = 4;
  localparam int DLY = 20;
  localparam int PER = 8;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [6:0] btn;
  logic       Right, Left, Up, Down, Select, Start, Ack;
  logic [6:0] outs;

  always #5 Clk = ~Clk;

  button_pulse_gen #(
    .DEB_CYCLES (DEB),
    .RPT_DELAY  (DLY),
    .RPT_PERIOD (PER),
    .CNT_W      (8)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .BtnR     (btn[0]),
    .BtnL     (btn[1]),
    .BtnU     (btn[2]),
    .BtnD     (btn[3]),
    .BtnC     (btn[4]),
    .BtnStart (btn[5]),
    .BtnAck   (btn[6]),
    .Right    (Right),
    .Left     (Left),
    .Up       (Up),
    .Down     (Down),
    .Select   (Select),
    .Start    (Start),
    .Ack      (Ack)
  );

  assign outs = {Ack, Start, Select, Down, Up, Left, Right};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int c0;

  // Reference model: synchronizer delay line plus per-button run-length
  // bookkeeping.
  logic [6:0] m_s1, m_s2, exp_out;
  bit held [7];
  bit skip [7];
  bit mute [7];
  int run1 [7];
  int run0 [7];
  int hcnt [7];
  int nrep [7];

  int npulse [7];
  int first_pulse [7];
  int last_pulse [7];

  function automatic void model_reset();
    m_s1 = '0;
    m_s2 = '0;
    exp_out = '0;
    for (int i = 0; i < 7; i++) begin
      held[i] = 0; skip[i] = 0; mute[i] = 0;
      run1[i] = 0; run0[i] = 0; hcnt[i] = 0; nrep[i] = 0;
    end
  endfunction

  function automatic void model_edge();
    logic [6:0] w;
    logic [6:0] fire;
    bit taken;
    w    = m_s2;
    m_s2 = m_s1;
    m_s1 = btn;
    fire = '0;
    for (int i = 0; i < 7; i++) begin
      if (!held[i]) begin
        // A press needs DEB+1 consecutive high samples.
        if (w[i]) begin
          run1[i]++;
          if (run1[i] == DEB + 1) begin
            fire[i] = 1'b1; held[i] = 1; skip[i] = 1;
            hcnt[i] = 0; run0[i] = 0; nrep[i] = 1; run1[i] = 0;
          end
        end else begin
          run1[i] = 0;
        end
      end else if (skip[i]) begin
        // The pulse cycle itself does not look at the button.
        skip[i] = 0;
      end else if (run0[i] > 0) begin
        if (w[i]) begin
          run0[i] = 0;
          hcnt[i] = 0;
        end else begin
          run0[i]++;
          if (run0[i] == DEB + 1) begin
            held[i] = 0; run0[i] = 0; run1[i] = 0; mute[i] = 0;
          end
        end
      end else if (!w[i]) begin
        run0[i] = 1;
      end else if (i < 4) begin
        hcnt[i]++;
        if (hcnt[i] == ((nrep[i] > 1) ? PER : DLY)) begin
          fire[i] = 1'b1; skip[i] = 1; hcnt[i] = 0; nrep[i]++;
        end
      end
    end
    exp_out = '0;
    taken = 0;
    for (int i = 0; i < 5; i++) begin
      if (fire[i] && !mute[i]) begin
        if (!taken) begin
          exp_out[i] = 1'b1;
          taken = 1;
        end else begin
          mute[i] = 1;
        end
      end
    end
    exp_out[5] = fire[5];
    exp_out[6] = fire[6];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 7; i++) begin
      npulse[i] = 0;
      first_pulse[i] = -1;
      last_pulse[i] = -1;
    end
  endtask

  task automatic step();
    @(posedge Clk);
    cyc++;
    model_edge();
    @(negedge Clk);
    chk("outputs", {25'd0, outs}, {25'd0, exp_out});
    for (int i = 0; i < 7; i++) begin
      if (outs[i]) begin
        if (npulse[i] == 0) first_pulse[i] = cyc;
        npulse[i]++;
        last_pulse[i] = cyc;
      end
    end
  endtask

  task automatic steps(input int n);
    for (int j = 0; j < n; j++) step();
  endtask

  function automatic int others(input int keep);
    int s = 0;
    for (int i = 0; i < 7; i++) if (i != keep) s += npulse[i];
    return s;
  endfunction

  initial begin
    Reset = 1'b1;
    btn   = '0;
    model_reset();
    clear_counts();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("reset_outs", {25'd0, outs}, 32'd0);
    Reset = 1'b0;
    steps(3);

    // Clean press on R.
    clear_counts();
    c0 = cyc + 1;
    btn = 7'b0000001;
    steps(12);
    btn = '0;
    steps(14);
    chk("clean_r_count", npulse[0], 1);
    chk("clean_r_time", first_pulse[0], c0 + 6);
    chk("clean_others", others(0), 0);

    // Bounce on U: 1,1,1,0 then stable high.
    clear_counts();
    c0 = cyc + 1;
    btn = 7'b0000100;
    steps(3);
    btn = '0;
    steps(1);
    btn = 7'b0000100;
    steps(15);
    btn = '0;
    steps(14);
    chk("bounce_u_count", npulse[2], 1);
    chk("bounce_u_time", first_pulse[2], c0 + 10);

    // Auto-repeat on D for 60 edges.
    clear_counts();
    c0 = cyc + 1;
    btn = 7'b0001000;
    steps(60);
    btn = '0;
    steps(14);
    chk("rpt_d_count", npulse[3], 5);
    chk("rpt_d_first", first_pulse[3], c0 + 6);
    chk("rpt_d_last", last_pulse[3], c0 + 54);

    // Select never repeats.
    clear_counts();
    c0 = cyc + 1;
    btn = 7'b0010000;
    steps(60);
    btn = '0;
    steps(14);
    chk("sel_count", npulse[4], 1);
    chk("sel_time", first_pulse[4], c0 + 6);

    // R and L together: R wins, L stays silent through repeats.
    clear_counts();
    c0 = cyc + 1;
    btn = 7'b0000011;
    steps(30);
    btn = '0;
    steps(14);
    chk("rl_right_count", npulse[0], 2);
    chk("rl_right_time", first_pulse[0], c0 + 6);
    chk("rl_left_count", npulse[1], 0);

    // After release L is live again.
    clear_counts();
    btn = 7'b0000010;
    steps(10);
    btn = '0;
    steps(14);
    chk("l_repress_count", npulse[1], 1);

    // Start rises with R: both pulse in the same cycle.
    clear_counts();
    c0 = cyc + 1;
    btn = 7'b0100001;
    steps(10);
    btn = '0;
    steps(14);
    chk("start_count", npulse[5], 1);
    chk("start_time", first_pulse[5], c0 + 6);
    chk("start_r_time", first_pulse[0], c0 + 6);

    // Reset while R is held in HOLD, then released with R still high.
    btn = 7'b0000001;
    steps(10);
    Reset = 1'b1;
    #1;
    chk("rst_hold_outs", {25'd0, outs}, 32'd0);
    model_reset();
    clear_counts();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    c0 = cyc + 1;
    steps(7);
    chk("rst_repress_count", npulse[0], 1);
    chk("rst_repress_time", first_pulse[0], c0 + 6);
    // Reset during the pulse cycle clears the output at once.
    Reset = 1'b1;
    #1;
    chk("rst_pulse_right", {31'd0, Right}, 32'd0);
    model_reset();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    btn = '0;
    steps(5);

    // Random activity, from long holds to heavy bouncing.
    for (int seg = 0; seg < 4; seg++) begin
      int p;
      case (seg)
        0: p = 2;
        1: p = 8;
        2: p = 25;
        default: p = 4;
      endcase
      for (int n = 0; n < 600; n++) begin
        for (int i = 0; i < 7; i++)
          if ($urandom_range(0, 99) < p) btn[i] = ~btn[i];
        if ($urandom_range(0, 99) < 2) btn = 7'($urandom_range(0, 127));
        if (seg == 3 && n == 300) begin
          Reset = 1'b1;
          #1;
          chk("rst_random_outs", {25'd0, outs}, 32'd0);
          model_reset();
          @(posedge Clk);
          @(negedge Clk);
          Reset = 1'b0;
        end
        step();
      end
    end

    btn = '0;
    steps(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_pulse_gen.md
# button_pulse_gen

Front-end conditioning stage for the 4x4 memory game on the board. It synchronizes and debounces seven raw push-buttons, then turns each clean press into a single-clock pulse. The game FSM consumes these pulses directly as `Right`, `Left`, `Up`, `Down`, `Select`, `Start` and `Ack`, so one physical press moves the cursor or selects a cell exactly once. Direction buttons auto-repeat while held, and game-control pulses are made mutually exclusive.

## Interface

Parameters:
- `DEB_CYCLES`, default 500000 — consecutive stable synchronized samples required to accept a press or a release (5 ms at 100 MHz).
- `RPT_DELAY`, default 50000000 — hold cycles before the first auto-repeat.
- `RPT_PERIOD`, default 15000000 — hold cycles between later auto-repeats.
- `CNT_W`, default 26 — per-channel counter width; must hold the maximum of the three counts above.

Ports:
- `Clk`  in  1  system clock.
- `Reset`  in  1  asynchronous, active-high reset.
- `BtnR, BtnL, BtnU, BtnD, BtnC`  in  1 each  raw, asynchronous, active-high game buttons. `BtnC` is Select.
- `BtnStart, BtnAck`  in  1 each  raw, asynchronous, active-high control buttons.
- `Right, Left, Up, Down, Select`  out  1 each  single-cycle game pulses.
- `Start, Ack`  out  1 each  single-cycle control pulses.

## Operation

- **Synchronizer:** each raw input passes through a 2-flop synchronizer (`s1`, `s2`); both flops reset to 0.
- **Per-channel FSM** (7 identical instances), with states IDLE, DEB_PRESS, PULSE, HOLD, DEB_REL, plus a `cnt[CNT_W-1:0]` counter and a `rpt` flag:
  - **IDLE:** `cnt`=0, `rpt`=0. If `s2`=1, go to DEB_PRESS with `cnt`=0.
  - **DEB_PRESS:** if `s2`=0, return to IDLE. Otherwise, if `cnt`==`DEB_CYCLES`-1, go to PULSE; else `cnt`++.
  - **PULSE:** lasts exactly one cycle, then goes to HOLD with `cnt`=0.
  - **HOLD:**
    - If `s2`=0, go to DEB_REL with `cnt`=0. Release has priority over repeat.
    - Otherwise, on repeat channels (R, L, U, D) only: when `cnt`==(`rpt` ? `RPT_PERIOD` : `RPT_DELAY`)-1, go to PULSE and set `rpt`=1; else `cnt`++.
    - Select, Start and Ack never repeat.
  - **DEB_REL:** if `s2`=1 (bounce), return to HOLD with `cnt`=0, keeping `rpt`. If `s2`=0 and `cnt`==`DEB_CYCLES`-1, go to IDLE; else `cnt`++.
- **Outputs:** registered. A channel's output is 1 exactly while that channel is in PULSE.
- **Game arbitration:**
  - At most one of `Right`/`Left`/`Up`/`Down`/`Select` may be high in any cycle.
  - If several game channels enter PULSE on the same edge, fixed priority R > L > U > D > C applies.
  - Losing channels proceed to HOLD with their pulse dropped, never deferred. They generate nothing until they are released and pressed again; repeats are also suppressed.
  - `Start` and `Ack` are never arbitrated and may coincide with each other or with a game pulse.
- **Reset:** asynchronously forces all outputs to 0, all FSMs to IDLE, and all `cnt`, `rpt` and synchronizer flops to 0. This includes reset mid-debounce or mid-hold. A button still held when reset is released must complete a full press debounce again, then pulses once.

## Timing

- Let edge k be the first edge at which `s1` samples 1.
  - `s2`=1 after edge k+1.
  - DEB_PRESS is entered at edge k+2.
  - The pulse is high from edge k+`DEB_CYCLES`+2 to edge k+`DEB_CYCLES`+3, if the input stays high throughout.
- **Auto-repeat:** pulse start-to-start spacing is `RPT_DELAY`+1 for the first repeat and `RPT_PERIOD`+1 thereafter.
- **Release:** the FSM leaves HOLD at edge r+2, where edge r is the first edge at which `s1` samples 0.
- **Minimum re-press interval:** a new press is accepted only after `DEB_CYCLES` stable-low samples.
- **Pulse width:** always exactly one `Clk` period; no output is ever high on two consecutive cycles.

## Test plan

All cases use `DEB_CYCLES`=4, `RPT_DELAY`=20, `RPT_PERIOD`=8, `CNT_W`=8.

- **Clean press:** `BtnR` held high from edge k for 12 cycles → `Right`=1 only in the cycle starting at edge k+6. No other outputs.
- **Bounce:** `BtnU` pattern 1,1,1,0 then stable 1 → no pulse from the first burst; exactly one `Up` pulse, starting 4 edges after the stable run is first seen at `s2` plus 2.
- **Auto-repeat:** `BtnD` high for edges k..k+59 → `Down` pulses start at k+6, k+27, k+36, k+45, k+54, and none after. `BtnC` held 60 cycles → exactly one `Select` pulse.
- **Simultaneous game buttons:** `BtnR` and `BtnL` rise on the same edge → one `Right` pulse only; `Left` never pulses while held.
- **Simultaneous control and game:** `BtnStart` rises with `BtnR` → `Start` and `Right` pulse in the same cycle.
- **Reset mid-hold:** assert `Reset` while `BtnR` is in HOLD → `Right`=0 immediately. Deassert `Reset` with `BtnR` still high → one `Right` pulse 6 edges after the first post-reset sampling edge.
